// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner PHY datapath.
package tuner_phy_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      SETTLE   = 2'd1,
      ACCUM    = 2'd2
   } tuner_pwr_fe_state_e;

endpackage

// File: rtl/tuner_pwr_accum.sv
// Power accumulator: sums valid samples until 2^N have been seen and presents the
// truncated mean combinationally alongside the completing sample.
module tuner_pwr_accum #(
   parameter int ADC_WIDTH    = 8,
   parameter int MAX_AVG_LOG2 = 4,
   parameter int N_WIDTH      = $clog2(MAX_AVG_LOG2 + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clear,
   input  logic                 i_add,
   input  logic [ADC_WIDTH-1:0] i_data,
   input  logic [N_WIDTH-1:0]   i_n,
   output logic                 o_done,
   output logic [ADC_WIDTH-1:0] o_result
);

   localparam int ACC_W = ADC_WIDTH + MAX_AVG_LOG2;
   localparam int CNT_W = MAX_AVG_LOG2 + 1;

   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;

   always_comb begin
      acc_sum  = acc_q + ACC_W'(i_data);
      cnt_sum  = cnt_q + CNT_W'(1);
      o_done   = i_add && !i_clear && (cnt_sum == (CNT_W'(1) << i_n));
      o_result = ADC_WIDTH'(acc_sum >> i_n);
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      // A completing sample restarts the window on the same edge, so windows run back to back.
      if (i_clear || o_done) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (i_add) begin
         acc_d = acc_sum;
         cnt_d = cnt_sum;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tuner_pwr_frontend.sv
// Ring-power front end: blanks after every tune change, averages 2^N samples and tags
// each result with the tune code it was measured at.
module tuner_pwr_frontend
   import tuner_phy_pkg::*;
#(
   parameter int ADC_WIDTH    = 8,
   parameter int DAC_WIDTH    = 8,
   parameter int MAX_AVG_LOG2 = 4,
   parameter int SETTLE_WIDTH = 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_en,
   input  logic [ADC_WIDTH-1:0]              i_adc_data,
   input  logic                              i_adc_val,
   input  logic [DAC_WIDTH-1:0]              i_dig_ring_tune,
   input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] i_cfg_avg_log2,
   input  logic [SETTLE_WIDTH-1:0]           i_cfg_settle_cycles,
   output logic [ADC_WIDTH-1:0]              o_dig_ring_pwr,
   output logic                              o_pwr_val,
   output logic [DAC_WIDTH-1:0]              o_dig_ring_tune_tag,
   output tuner_pwr_fe_state_e               o_state_mon
);

   localparam int N_WIDTH = $clog2(MAX_AVG_LOG2 + 1);

   function automatic logic [N_WIDTH-1:0] sat_avg_log2(input logic [N_WIDTH-1:0] n);
      return (n > N_WIDTH'(MAX_AVG_LOG2)) ? N_WIDTH'(MAX_AVG_LOG2) : n;
   endfunction

   tuner_pwr_fe_state_e     state_q, state_d;
   logic [SETTLE_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
   logic [DAC_WIDTH-1:0]    last_tune_q, last_tune_d;
   logic [DAC_WIDTH-1:0]    win_tag_q, win_tag_d;
   logic [N_WIDTH-1:0]      n_win_q, n_win_d;
   logic [ADC_WIDTH-1:0]    pwr_q, pwr_d;
   logic                    pwr_val_q, pwr_val_d;
   logic [DAC_WIDTH-1:0]    tag_q, tag_d;

   logic                    tune_chg, load_settle, acc_add, acc_clear, acc_done;
   logic [ADC_WIDTH-1:0]    acc_result;

   assign tune_chg = (state_q != DISABLED) && (i_dig_ring_tune != last_tune_q);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= DISABLED;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DISABLED: if (i_en) state_d = SETTLE;
         SETTLE: begin
            if (!i_en)                                     state_d = DISABLED;
            else if (tune_chg)                             state_d = SETTLE;
            else if (settle_cnt_q <= SETTLE_WIDTH'(1))     state_d = ACCUM;
         end
         ACCUM: begin
            if (!i_en)         state_d = DISABLED;
            else if (tune_chg) state_d = SETTLE;
         end
         default: state_d = DISABLED;
      endcase
   end

   // A tune change outranks a completing sample: the window is dropped without a pulse.
   always_comb begin
      load_settle  = i_en && ((state_q == DISABLED) || tune_chg);
      acc_add      = (state_q == ACCUM) && i_en && !tune_chg && i_adc_val;
      acc_clear    = (state_q != ACCUM) || !i_en || tune_chg;
      last_tune_d  = i_dig_ring_tune;
      win_tag_d    = load_settle ? i_dig_ring_tune : win_tag_q;
      n_win_d      = ((state_q == SETTLE) && (state_d == ACCUM)) ? sat_avg_log2(i_cfg_avg_log2)
                                                                 : n_win_q;
      settle_cnt_d = settle_cnt_q;
      if ((state_q == SETTLE) && (settle_cnt_q != '0)) settle_cnt_d = settle_cnt_q - SETTLE_WIDTH'(1);
      if (load_settle)                                 settle_cnt_d = i_cfg_settle_cycles;
      if (!i_en)                                       settle_cnt_d = '0;
      pwr_val_d    = acc_done;
      pwr_d        = acc_done ? acc_result : pwr_q;
      tag_d        = acc_done ? win_tag_q  : tag_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         settle_cnt_q <= '0;
         last_tune_q  <= '0;
         win_tag_q    <= '0;
         n_win_q      <= '0;
         pwr_q        <= '0;
         pwr_val_q    <= 1'b0;
         tag_q        <= '0;
      end else begin
         settle_cnt_q <= settle_cnt_d;
         last_tune_q  <= last_tune_d;
         win_tag_q    <= win_tag_d;
         n_win_q      <= n_win_d;
         pwr_q        <= pwr_d;
         pwr_val_q    <= pwr_val_d;
         tag_q        <= tag_d;
      end
   end

   tuner_pwr_accum #(
      .ADC_WIDTH    (ADC_WIDTH),
      .MAX_AVG_LOG2 (MAX_AVG_LOG2),
      .N_WIDTH      (N_WIDTH)
   ) u_accum (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (acc_clear),
      .i_add    (acc_add),
      .i_data   (i_adc_data),
      .i_n      (n_win_q),
      .o_done   (acc_done),
      .o_result (acc_result)
   );

   assign o_dig_ring_pwr      = pwr_q;
   assign o_pwr_val           = pwr_val_q;
   assign o_dig_ring_tune_tag = tag_q;
   assign o_state_mon         = state_q;

endmodule

// File: tb/tb_tuner_pwr_frontend.sv
// Bench for tuner_pwr_frontend: directed vector table, corner-case sequences and a
// randomized run compared every cycle against a window-level reference model.
module tb_tuner_pwr_frontend;
   import tuner_phy_pkg::*;

   localparam int MAX_N = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                en;
   logic                val;
   logic [7:0]          data;
   logic [7:0]          tune;
   logic [2:0]          cfg_n;
   logic [7:0]          cfg_settle;
   logic [7:0]          pwr;
   logic                pwr_val;
   logic [7:0]          tag;
   tuner_pwr_fe_state_e state_mon;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tuner_pwr_frontend #(
      .ADC_WIDTH(8), .DAC_WIDTH(8), .MAX_AVG_LOG2(MAX_N), .SETTLE_WIDTH(8)
   ) dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_en                (en),
      .i_adc_data          (data),
      .i_adc_val           (val),
      .i_dig_ring_tune     (tune),
      .i_cfg_avg_log2      (cfg_n),
      .i_cfg_settle_cycles (cfg_settle),
      .o_dig_ring_pwr      (pwr),
      .o_pwr_val           (pwr_val),
      .o_dig_ring_tune_tag (tag),
      .o_state_mon         (state_mon)
   );

   // Reference model: a window is a list of samples; the result is its integer mean.
   int m_active, m_settling, m_blank, m_tag, m_last_tune, m_n;
   int m_val, m_pwr, m_out_tag;
   int win_q[$];

   task automatic model_reset();
      m_active = 0; m_settling = 0; m_blank = 0; m_tag = 0; m_last_tune = 0; m_n = 0;
      m_val = 0; m_pwr = 0; m_out_tag = 0;
      win_q.delete();
   endtask

   task automatic model_step();
      int sum;
      m_val = 0;
      if (!en) begin
         m_active = 0; m_settling = 0; win_q.delete();
      end else if (m_active == 0 || int'(tune) != m_last_tune) begin
         m_active = 1; m_settling = 1;
         m_blank = (cfg_settle == 8'd0) ? 1 : int'(cfg_settle);
         m_tag = int'(tune);
         win_q.delete();
      end else if (m_settling != 0) begin
         m_blank--;
         if (m_blank == 0) begin
            m_settling = 0;
            m_n = (int'(cfg_n) > MAX_N) ? MAX_N : int'(cfg_n);
         end
      end else if (val) begin
         win_q.push_back(int'(data));
         if (win_q.size() == (1 << m_n)) begin
            sum = 0;
            foreach (win_q[i]) sum += win_q[i];
            m_pwr = sum / (1 << m_n);
            m_out_tag = m_tag;
            m_val = 1;
            win_q.delete();
         end
      end
      m_last_tune = int'(tune);
   endtask

   function automatic int model_state();
      if (m_active == 0) return int'(DISABLED);
      return (m_settling != 0) ? int'(SETTLE) : int'(ACCUM);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      if (!rst_n) model_reset();
      else        model_step();
      @(posedge clk);
      #1;
      chk("model_pwr_val", int'(pwr_val), m_val);
      chk("model_pwr", int'(pwr), m_pwr);
      chk("model_tag", int'(tag), m_out_tag);
      chk("model_state", int'(state_mon), model_state());
   endtask

   task automatic send(input int d);
      val = 1'b1; data = 8'(d);
      cyc();
      val = 1'b0;
   endtask

   task automatic wait_accum(input string name);
      for (int i = 0; i < 300 && state_mon != ACCUM; i++) cyc();
      chk(name, int'(state_mon), int'(ACCUM));
   endtask

   task automatic restart();
      en = 1'b0; cyc();
      en = 1'b1; wait_accum("restart_accum");
   endtask

   typedef struct {
      int en, val, data, tune, n, settle;
      int ev, ep, et;
      tuner_pwr_fe_state_e es;
   } vec_t;

   function automatic vec_t mk(input int en_i, input int val_i, input int data_i, input int tune_i,
                               input int n_i, input int settle_i, input int ev, input int ep,
                               input int et, input tuner_pwr_fe_state_e es);
      vec_t v;
      v.en = en_i; v.val = val_i; v.data = data_i; v.tune = tune_i; v.n = n_i; v.settle = settle_i;
      v.ev = ev; v.ep = ep; v.et = et; v.es = es;
      return v;
   endfunction

   vec_t vt[15];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vt[0]  = mk(1, 0,   0, 'h10, 2, 3, 0,  0,    0, SETTLE);
      vt[1]  = mk(1, 1, 200, 'h10, 2, 3, 0,  0,    0, SETTLE);
      vt[2]  = mk(1, 0,   0, 'h10, 2, 3, 0,  0,    0, SETTLE);
      vt[3]  = mk(1, 0,   0, 'h10, 2, 3, 0,  0,    0, ACCUM);
      vt[4]  = mk(1, 1,  10, 'h10, 2, 3, 0,  0,    0, ACCUM);
      vt[5]  = mk(1, 1,  20, 'h10, 2, 3, 0,  0,    0, ACCUM);
      vt[6]  = mk(1, 1,  30, 'h10, 2, 3, 0,  0,    0, ACCUM);
      vt[7]  = mk(1, 1,  40, 'h10, 2, 3, 1, 25, 'h10, ACCUM);
      vt[8]  = mk(1, 0,   0, 'h10, 2, 3, 0, 25, 'h10, ACCUM);
      vt[9]  = mk(0, 0,   0, 'h10, 0, 0, 0, 25, 'h10, DISABLED);
      vt[10] = mk(1, 0,   0, 'h10, 0, 0, 0, 25, 'h10, SETTLE);
      vt[11] = mk(1, 0,   0, 'h10, 0, 0, 0, 25, 'h10, ACCUM);
      vt[12] = mk(1, 1,   7, 'h10, 0, 0, 1,  7, 'h10, ACCUM);
      vt[13] = mk(1, 1,   9, 'h10, 0, 0, 1,  9, 'h10, ACCUM);
      vt[14] = mk(1, 0,   0, 'h10, 0, 0, 0,  9, 'h10, ACCUM);

      rst_n = 1'b0; en = 1'b0; val = 1'b0; data = '0; tune = '0; cfg_n = '0; cfg_settle = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pwr", int'(pwr), 0);
      chk("reset_pwr_val", int'(pwr_val), 0);
      chk("reset_tag", int'(tag), 0);
      chk("reset_state", int'(state_mon), int'(DISABLED));
      #2 rst_n = 1'b1;

      foreach (vt[i]) begin
         en = (vt[i].en != 0); val = (vt[i].val != 0); data = 8'(vt[i].data);
         tune = 8'(vt[i].tune); cfg_n = 3'(vt[i].n); cfg_settle = 8'(vt[i].settle);
         cyc();
         chk($sformatf("vec%0d_pwr_val", i), int'(pwr_val), vt[i].ev);
         chk($sformatf("vec%0d_pwr", i), int'(pwr), vt[i].ep);
         chk($sformatf("vec%0d_tag", i), int'(tag), vt[i].et);
         chk($sformatf("vec%0d_state", i), int'(state_mon), int'(vt[i].es));
      end
      val = 1'b0;

      // Tune change after 5 of 8 samples aborts the window; the fresh window is tagged 0x11.
      cfg_n = 3'd3; cfg_settle = 8'd2; tune = 8'h10;
      restart();
      repeat (5) send(50);
      tune = 8'h11; cyc();
      chk("abort_state", int'(state_mon), int'(SETTLE));
      chk("abort_no_pulse", int'(pwr_val), 0);
      wait_accum("abort_resettle");
      repeat (7) send(100);
      chk("fresh7_no_pulse", int'(pwr_val), 0);
      send(100);
      chk("fresh8_pulse", int'(pwr_val), 1);
      chk("fresh8_pwr", int'(pwr), 100);
      chk("fresh8_tag", int'(tag), 'h11);

      // Tune change coinciding with the final sample of a window.
      cfg_n = 3'd2; cfg_settle = 8'd1;
      restart();
      send(1); send(2); send(3);
      tune = 8'h12; send(5);
      chk("coinc_no_pulse", int'(pwr_val), 0);
      chk("coinc_state", int'(state_mon), int'(SETTLE));
      wait_accum("coinc_resettle");
      send(1); send(2); send(3);
      chk("coinc_cnt_cleared", int'(pwr_val), 0);
      send(5);
      chk("coinc_pulse", int'(pwr_val), 1);
      chk("coinc_trunc_pwr", int'(pwr), 2);
      chk("coinc_tag", int'(tag), 'h12);

      // Saturated exponent, full-scale samples.
      cfg_n = 3'd7; cfg_settle = 8'd0;
      restart();
      repeat (15) send(255);
      chk("sat15_no_pulse", int'(pwr_val), 0);
      send(255);
      chk("sat16_pulse", int'(pwr_val), 1);
      chk("sat16_pwr", int'(pwr), 255);

      // Enable drop mid-window holds outputs.
      cfg_n = 3'd2; cfg_settle = 8'd2;
      restart();
      send(64); send(64);
      en = 1'b0; cyc();
      chk("endrop_state", int'(state_mon), int'(DISABLED));
      chk("endrop_no_pulse", int'(pwr_val), 0);
      chk("endrop_pwr_held", int'(pwr), 255);
      chk("endrop_tag_held", int'(tag), 'h12);
      en = 1'b1; cyc();
      chk("reenable_state", int'(state_mon), int'(SETTLE));

      // Asynchronous reset mid-window.
      wait_accum("prereset_accum");
      send(64); send(64); send(64);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("areset_pwr", int'(pwr), 0);
      chk("areset_pwr_val", int'(pwr_val), 0);
      chk("areset_tag", int'(tag), 0);
      chk("areset_state", int'(state_mon), int'(DISABLED));
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      chk("release_no_pulse", int'(pwr_val), 0);
      wait_accum("postreset_accum");
      repeat (4) send(64);
      chk("postreset_pulse", int'(pwr_val), 1);
      chk("postreset_pwr", int'(pwr), 64);

      // Randomized run against the model.
      for (int i = 0; i < 600; i++) begin
         if (en) begin
            if ($urandom_range(0, 49) == 0) en = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            en = 1'b1;
         end
         if ($urandom_range(0, 39) == 0) tune = tune + 8'd1;
         val        = ($urandom_range(0, 9) < 7);
         data       = 8'($urandom_range(0, 255));
         cfg_n      = 3'($urandom_range(0, 7));
         cfg_settle = 8'($urandom_range(0, 5));
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
